// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM demultiplexer: FSM state encoding and
// lane-index width derivation.
package tdm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } tdm_state_t;

    function automatic int tdm_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // A lane index always needs at least one bit, even for degenerate counts.
    function automatic int lane_idx_width(input int num_lanes);
        return (tdm_clog2(num_lanes) < 1) ? 1 : tdm_clog2(num_lanes);
    endfunction

    localparam int DEFAULT_NUM_LANES = 8;
    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_IDX_W     = lane_idx_width(DEFAULT_NUM_LANES);

endpackage

// File: rtl/tdm_demux_if.sv
// Framed word stream into the demultiplexer: valid/ready handshake plus a
// start-of-frame qualifier.
interface tdm_demux_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_sof, output in_data, input in_ready);
    modport slave  (input in_valid, input in_sof, input in_data, output in_ready);
endinterface

// File: rtl/tdm_lane_decoder.sv
// One-hot write-enable decoder for the shadow bank: lane k is enabled when the
// accept strobe is high and the target index equals k.
module tdm_lane_decoder #(
    parameter int NUM_LANES = 8,
    parameter int IDX_W     = 3
) (
    input  logic [IDX_W-1:0]     idx,
    input  logic                 strobe,
    output logic [NUM_LANES-1:0] lane_we
);
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_dec
            assign lane_we[gi] = strobe && (idx == IDX_W'(gi));
        end
    endgenerate
endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: collects word k of each frame into shadow lane k
// and publishes all lanes atomically when the last word of the frame arrives.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NUM_LANES = DEFAULT_NUM_LANES,
    parameter int WIDTH     = DEFAULT_WIDTH,
    localparam int IDX_W    = lane_idx_width(NUM_LANES)
) (
    input  logic                       clk,
    input  logic                       rst,
    tdm_demux_if.slave                 s,
    output logic [NUM_LANES*WIDTH-1:0] out_lanes,
    output logic                       out_frame_valid,
    output logic                       frame_err,
    output logic [IDX_W-1:0]           cur_lane
);
    localparam int LAST = NUM_LANES - 1;

    tdm_state_t                  state_reg;
    logic [IDX_W-1:0]            idx_reg;
    logic [WIDTH-1:0]            shadow_reg [LAST];
    logic [NUM_LANES*WIDTH-1:0]  out_lanes_reg;
    logic                        frame_valid_reg;
    logic                        frame_err_reg;

    logic                        accept;
    logic [IDX_W-1:0]            wr_idx;
    logic                        wr_strobe;
    logic [NUM_LANES-1:0]        lane_we;
    logic [NUM_LANES*WIDTH-1:0]  merged_next;

    assign s.in_ready = !rst && (state_reg != DONE);
    assign accept     = s.in_valid && s.in_ready;

    // A sof word always lands in lane 0; a non-sof word in IDLE is dropped.
    assign wr_idx    = s.in_sof ? '0 : idx_reg;
    assign wr_strobe = accept && (s.in_sof || (state_reg == COLLECT));

    tdm_lane_decoder #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IDX_W)
    ) u_dec (
        .idx     (wr_idx),
        .strobe  (wr_strobe),
        .lane_we (lane_we)
    );

    genvar gi;
    generate
        for (gi = 0; gi < LAST; gi++) begin : g_shadow
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg[gi] <= '0;
                end else if (lane_we[gi]) begin
                    shadow_reg[gi] <= s.in_data;
                end
            end
            assign merged_next[gi*WIDTH +: WIDTH] = shadow_reg[gi];
        end
    endgenerate

    // The final lane is taken straight from the bus on the completing accept.
    assign merged_next[LAST*WIDTH +: WIDTH] = s.in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            out_lanes_reg   <= '0;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (s.in_sof) begin
                            idx_reg   <= IDX_W'(1);
                            state_reg <= COLLECT;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (s.in_sof) begin
                            frame_err_reg <= 1'b1;
                            idx_reg       <= IDX_W'(1);
                        end else if (lane_we[LAST]) begin
                            out_lanes_reg   <= merged_next;
                            frame_valid_reg <= 1'b1;
                            idx_reg         <= '0;
                            state_reg       <= DONE;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out_lanes       = out_lanes_reg;
    assign out_frame_valid = frame_valid_reg;
    assign frame_err       = frame_err_reg;
    assign cur_lane        = idx_reg;
endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux with 4 lanes of 8 bits: a vector
// table for the basic frames plus hand sequences for multi-cycle cases.
module tb_tdm_demux;
    localparam int N = 4;
    localparam int W = 8;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] out_lanes;
    logic           out_frame_valid;
    logic           frame_err;
    logic [1:0]     cur_lane;

    int pass_cnt;
    int total_cnt;

    tdm_demux_if #(.WIDTH(W)) bus ();

    tdm_demux #(
        .NUM_LANES (N),
        .WIDTH     (W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s               (bus),
        .out_lanes       (out_lanes),
        .out_frame_valid (out_frame_valid),
        .frame_err       (frame_err),
        .cur_lane        (cur_lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        v;
        logic        s;
        logic [7:0]  d;
        logic        rdy;
        logic [31:0] lanes;
        logic        fv;
        logic        err;
        logic [1:0]  cur;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic v, input logic s,
                                input logic [7:0] d, input logic rdy,
                                input logic [31:0] lanes, input logic fv,
                                input logic err, input logic [1:0] cur);
        vec_t t;
        t.r = r; t.v = v; t.s = s; t.d = d; t.rdy = rdy;
        t.lanes = lanes; t.fv = fv; t.err = err; t.cur = cur;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // One clock cycle: drive inputs, check in_ready before the edge, then check
    // the registered outputs just after it.
    task automatic cyc(input string tag, input vec_t t);
        rst          = t.r;
        bus.in_valid = t.v;
        bus.in_sof   = t.s;
        bus.in_data  = t.d;
        #1;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(t.rdy));
        @(posedge clk);
        #1;
        chk({tag, ".out_lanes"}, out_lanes, t.lanes);
        chk({tag, ".out_frame_valid"}, 32'(out_frame_valid), 32'(t.fv));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(t.err));
        chk({tag, ".cur_lane"}, 32'(cur_lane), 32'(t.cur));
        $display("%s rst=%b v=%b sof=%b d=%h -> lanes=%h fv=%b err=%b cur=%0d",
                 tag, t.r, t.v, t.s, t.d, out_lanes, out_frame_valid, frame_err, cur_lane);
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        @(posedge clk);
        #1;

        // Reset, clean frame, sof-less words, early restart.
        vecs.push_back(mk(H, L, L, 8'h00, L, 32'h0, L, L, 2'd0));
        vecs.push_back(mk(H, H, H, 8'h99, L, 32'h0, L, L, 2'd0));
        vecs.push_back(mk(L, H, H, 8'h11, H, 32'h0, L, L, 2'd1));
        vecs.push_back(mk(L, H, L, 8'h22, H, 32'h0, L, L, 2'd2));
        vecs.push_back(mk(L, H, L, 8'h33, H, 32'h0, L, L, 2'd3));
        vecs.push_back(mk(L, H, L, 8'h44, H, 32'h44332211, H, L, 2'd0));
        vecs.push_back(mk(L, L, L, 8'h00, L, 32'h44332211, L, L, 2'd0));
        vecs.push_back(mk(L, L, L, 8'h00, H, 32'h44332211, L, L, 2'd0));
        vecs.push_back(mk(L, H, L, 8'hAA, H, 32'h44332211, L, H, 2'd0));
        vecs.push_back(mk(L, H, L, 8'hBB, H, 32'h44332211, L, H, 2'd0));
        vecs.push_back(mk(L, L, L, 8'h00, H, 32'h44332211, L, L, 2'd0));
        vecs.push_back(mk(L, H, H, 8'h01, H, 32'h44332211, L, L, 2'd1));
        vecs.push_back(mk(L, H, L, 8'h02, H, 32'h44332211, L, L, 2'd2));
        vecs.push_back(mk(L, H, H, 8'h10, H, 32'h44332211, L, H, 2'd1));
        vecs.push_back(mk(L, H, L, 8'h20, H, 32'h44332211, L, L, 2'd2));
        vecs.push_back(mk(L, H, L, 8'h30, H, 32'h44332211, L, L, 2'd3));
        vecs.push_back(mk(L, H, L, 8'h40, H, 32'h40302010, H, L, 2'd0));
        vecs.push_back(mk(L, L, L, 8'h00, L, 32'h40302010, L, L, 2'd0));
        vecs.push_back(mk(L, L, L, 8'h00, H, 32'h40302010, L, L, 2'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            cyc($sformatf("vec%0d", i), vecs[i]);
        end

        // Gapped frame right after reset: out_lanes stays 0 until completion.
        cyc("gap.rst", mk(H, L, L, 8'h00, L, 32'h0, L, L, 2'd0));
        for (int k = 0; k < N; k++) begin
            logic [7:0] wd;
            wd = 8'(8'h11 * (k + 1));
            if (k == N - 1) begin
                cyc($sformatf("gap.w%0d", k), mk(L, H, L, wd, H, 32'h44332211, H, L, 2'd0));
            end else begin
                cyc($sformatf("gap.w%0d", k), mk(L, H, (k == 0), wd, H, 32'h0, L, L, 2'(k + 1)));
                for (int g = 0; g < 3; g++) begin
                    cyc($sformatf("gap.w%0d.idle%0d", k, g),
                        mk(L, L, L, 8'h5A, H, 32'h0, L, L, 2'(k + 1)));
                end
            end
        end
        cyc("gap.done", mk(L, L, L, 8'h00, L, 32'h44332211, L, L, 2'd0));

        // Back-to-back frames with in_valid held high: 5-cycle period.
        cyc("b2b.a0", mk(L, H, H, 8'hA1, H, 32'h44332211, L, L, 2'd1));
        cyc("b2b.a1", mk(L, H, L, 8'hA2, H, 32'h44332211, L, L, 2'd2));
        cyc("b2b.a2", mk(L, H, L, 8'hA3, H, 32'h44332211, L, L, 2'd3));
        cyc("b2b.a3", mk(L, H, L, 8'hA4, H, 32'hA4A3A2A1, H, L, 2'd0));
        cyc("b2b.stall", mk(L, H, H, 8'hB1, L, 32'hA4A3A2A1, L, L, 2'd0));
        cyc("b2b.b0", mk(L, H, H, 8'hB1, H, 32'hA4A3A2A1, L, L, 2'd1));
        cyc("b2b.b1", mk(L, H, L, 8'hB2, H, 32'hA4A3A2A1, L, L, 2'd2));
        cyc("b2b.b2", mk(L, H, L, 8'hB3, H, 32'hA4A3A2A1, L, L, 2'd3));
        cyc("b2b.b3", mk(L, H, L, 8'hB4, H, 32'hB4B3B2B1, H, L, 2'd0));
        cyc("b2b.done", mk(L, L, L, 8'h00, L, 32'hB4B3B2B1, L, L, 2'd0));

        // Reset after three words discards the partial frame.
        cyc("mrst.w0", mk(L, H, H, 8'h01, H, 32'hB4B3B2B1, L, L, 2'd1));
        cyc("mrst.w1", mk(L, H, L, 8'h02, H, 32'hB4B3B2B1, L, L, 2'd2));
        cyc("mrst.w2", mk(L, H, L, 8'h03, H, 32'hB4B3B2B1, L, L, 2'd3));
        cyc("mrst.rst", mk(H, H, L, 8'h04, L, 32'h0, L, L, 2'd0));
        cyc("mrst.idle", mk(L, L, L, 8'h00, H, 32'h0, L, L, 2'd0));
        cyc("mrst.f0", mk(L, H, H, 8'h05, H, 32'h0, L, L, 2'd1));
        cyc("mrst.f1", mk(L, H, L, 8'h06, H, 32'h0, L, L, 2'd2));
        cyc("mrst.f2", mk(L, H, L, 8'h07, H, 32'h0, L, L, 2'd3));
        cyc("mrst.f3", mk(L, H, L, 8'h08, H, 32'h08070605, H, L, 2'd0));
        cyc("mrst.done", mk(L, L, L, 8'h00, L, 32'h08070605, L, L, 2'd0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
# tdm_demux

Sequential time-division demultiplexer: accepts a framed stream of words on a single valid/ready input and distributes word k of each frame to output lane k. It presents all lanes together, atomically, once the whole frame has arrived. It is the receive-side counterpart to the lane-select muxing used to serialise per-actuator values (e.g. leg/servo set-points) onto one path. It sits between the serialised command path and the per-channel consumers.

## Interface
- NUM_LANES, 8, number of output lanes; legal range 2..64.
- WIDTH, 8, bits per word/lane.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_sof  input  1  qualifies the current word as lane 0 of a new frame.
- in_data  input  WIDTH  input word.
- out_lanes  output  NUM_LANES*WIDTH  published lane values; lane k occupies bits [k*WIDTH +: WIDTH].
- out_frame_valid  output  1  one-cycle pulse: out_lanes just updated with a complete frame.
- frame_err  output  1  one-cycle pulse: framing error detected.
- cur_lane  output  clog2(NUM_LANES)  index the next accepted word will be written to (0 when idle).

## Operation
- Accept = in_valid & in_ready. in_ready = !rst & (state != DONE), combinational from state.
- Words are written to a shadow register bank. out_lanes changes only at frame completion, never partially.
- States:
  - IDLE: waiting for frame start. Accept with in_sof=1 writes shadow[0], sets idx=1, and moves to COLLECT. Accept with in_sof=0 discards the word and pulses frame_err.
  - COLLECT: accept with in_sof=0 writes shadow[idx] and sets idx+1. Accept with in_sof=1 (early restart) pulses frame_err, writes shadow[0] and sets idx=1, staying in COLLECT. When the word for idx=NUM_LANES-1 is accepted, out_lanes loads the shadow merged with that word, out_frame_valid is set, and the state moves to DONE.
  - DONE: exactly one cycle. in_ready=0, out_frame_valid=1. Then IDLE with idx=0.
- A gap (in_valid=0) in any state holds state, idx and shadow indefinitely; there is no timeout.
- The shadow is not cleared between frames. Stale shadow contents are never published, because every lane is rewritten before completion.
- idx never wraps past NUM_LANES-1. The completion transition returns it to 0.
- Reset values: state IDLE, idx 0, shadow 0, out_lanes 0, out_frame_valid 0, frame_err 0, cur_lane 0; in_ready 0 while rst=1.
- Reset mid-frame discards the partial frame. out_lanes clears to 0, and no out_frame_valid or frame_err is produced in or after the reset cycle.

## Timing
- Throughput: one word per cycle during a frame, then 1 bubble cycle (DONE). Peak rate is NUM_LANES words per NUM_LANES+1 cycles.
- Latency: last word accepted at edge k. out_lanes and out_frame_valid are visible after edge k. out_frame_valid falls after edge k+1, and in_ready returns after edge k+1.
- frame_err is registered: high for the one cycle following the offending accept edge.
- Early-restart error and the new frame start occur on the same accept. No word is lost.
- cur_lane = idx, registered; it reflects accepts up to the previous edge.

## Structure
- Package tdm_pkg holds:
  - the state enum (IDLE, COLLECT, DONE), 2-bit encoding;
  - a clog2 helper function;
  - the lane-index width localparam derivation.
- Sub-module tdm_lane_decoder: combinational one-hot write-enable decoder that takes idx and the accept strobe and produces NUM_LANES enables for the shadow bank. This is the demux core.
- Top level holds the FSM, idx counter, shadow bank, output register and pulse flops.

## Test plan
All scenarios use NUM_LANES=4, WIDTH=8.
- Reset then one clean frame 0x11,0x22,0x33,0x44 (sof on first, back-to-back) -> out_lanes=0x44332211, out_frame_valid pulse 1 cycle after the 4th accept, in_ready low exactly 1 cycle, frame_err never set.
- Frame with in_valid gaps of 3 cycles between words -> identical result to the back-to-back frame. out_lanes holds its previous value (0) until completion.
- Words 0xAA,0xBB without sof from IDLE -> two frame_err pulses, no out_frame_valid, out_lanes unchanged.
- Sof frame 0x01,0x02, then sof 0x10,0x20,0x30,0x40 -> one frame_err pulse after the second sof accept, then out_lanes=0x40302010 with a single out_frame_valid.
- Two frames back-to-back with in_valid held high -> 5-cycle period. The second frame's first word is accepted the cycle after DONE, and both publishes are correct.
- rst asserted for 1 cycle after 3 words of a frame -> out_lanes=0, no pulses. The next full frame 0x05,0x06,0x07,0x08 publishes 0x08070605.
